// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer between execute and data memory.
// Requests are legality-checked on accept; legal ones drive the memory port for one issue cycle,
// faulting ones go straight to the response state without touching memory.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [2:0]  req_func,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic        mem_rw,
    output logic [2:0]  mem_func,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [1:0]  FLT_OK     = 2'b00;
    localparam logic [1:0]  FLT_ALIGN  = 2'b01;
    localparam logic [1:0]  FLT_RANGE  = 2'b10;
    localparam logic [1:0]  FLT_FUNC   = 2'b11;
    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_is_store;
    logic        r_mem_rw;
    logic [2:0]  r_mem_func;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_resp_rdata;
    logic [1:0]  r_resp_fault;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_range;
    logic [1:0]  w_fault;

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // Legality of the presented request, in priority order func > alignment > range
    always_comb begin
        w_illegal  = (req_func[1:0] == 2'b11) || (req_rw && req_func[2]) || (req_func == 3'b110);
        w_misalign = ((req_func[1:0] == 2'b01) && req_addr[0])
                  || ((req_func[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_range    = (req_addr >= ADDR_LIMIT);
        if (w_illegal) begin
            w_fault = FLT_FUNC;
        end else if (w_misalign) begin
            w_fault = FLT_ALIGN;
        end else if (w_range) begin
            w_fault = FLT_RANGE;
        end else begin
            w_fault = FLT_OK;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state sequencing: faults skip memory, stores skip capture
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (w_fault != FLT_OK) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE:   w_state_nxt = r_is_store ? S_RESP : S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, memory port and response registers; mem_rw is a single-cycle pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_store   <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_func   <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_rdata <= '0;
            r_resp_fault <= FLT_OK;
        end else begin
            r_mem_rw <= 1'b0;
            if (w_accept) begin
                r_is_store   <= req_rw;
                r_resp_fault <= w_fault;
                r_resp_rdata <= '0;
                if (w_fault == FLT_OK) begin
                    r_mem_rw    <= req_rw;
                    r_mem_func  <= req_func;
                    r_mem_addr  <= req_addr;
                    r_mem_wdata <= req_wdata;
                end
            end
            if (r_state == S_CAPTURE) begin
                r_resp_rdata <= mem_rdata;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_fault = r_resp_fault;
    assign mem_rw     = r_mem_rw;
    assign mem_func   = r_mem_func;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a cycle-count behavioural model and a memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [2:0]  req_func;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic        mem_rw;
    logic [2:0]  mem_func;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_BYTES(65536)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_func(req_func),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_rw(mem_rw), .mem_func(mem_func), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rw_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int unsigned nbytes(input logic [2:0] f);
        return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // ---------------- data memory (environment) ----------------
    bit [7:0] env_mem [65536];

    function automatic logic [31:0] env_read(input logic [2:0] f, input logic [31:0] a);
        int unsigned n;
        logic [31:0] v;
        logic [15:0] idx;
        n = nbytes(f);
        v = '0;
        for (int unsigned i = 0; i < n; i++) begin
            idx = a[15:0] + 16'(i);
            v[8*i +: 8] = env_mem[idx];
        end
        if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst_n === 1'b1 && mem_rw === 1'b1) begin
            for (int unsigned i = 0; i < nbytes(mem_func); i++) begin
                env_mem[16'(mem_addr[15:0] + 16'(i))] <= mem_wdata[8*i +: 8];
            end
        end
        mem_rdata <= env_read(mem_func, mem_addr);
    end

    // ---------------- behavioural model ----------------
    bit [7:0] ref_mem [65536];

    function automatic logic [1:0] model_fault(input logic rw, input logic [2:0] f, input logic [31:0] a);
        if (f[1:0] == 2'b11 || (rw && f[2]) || f == 3'b110) return 2'b11;
        if ((a % nbytes(f)) != 0) return 2'b01;
        if (a >= 32'd65536) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] f, input logic [31:0] a);
        int unsigned n;
        logic [31:0] v;
        n = nbytes(f);
        v = '0;
        for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8*i));
        if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic model_write(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        for (int unsigned i = 0; i < nbytes(f); i++) ref_mem[a + i] = d[8*i +: 8];
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic [1:0]  fault;
    } hs_t;
    hs_t hs_q[$];

    bit          m_live = 0;
    bit          m_busy = 0;
    bit          m_zero = 0;
    int          m_acc = 0;
    int          m_lat = 0;
    logic        m_store = 0;
    logic [2:0]  m_func = '0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [1:0]  m_fault = '0;
    logic [31:0] m_rdata = '0;
    logic [2:0]  m_mfunc = '0;
    logic [31:0] m_maddr = '0;
    logic [31:0] m_mwdata = '0;
    logic        e_ready, e_valid, e_rw;
    hs_t         h;

    // Compare DUT against the model every cycle, then advance the model to the next edge
    always @(negedge clk) begin
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            h.cyc = cyc; h.rdata = resp_rdata; h.fault = resp_fault;
            hs_q.push_back(h);
        end
        if (mem_rw === 1'b1) rw_cnt++;
        e_valid = 1'b0;
        e_rw    = 1'b0;
        if (m_live) begin
            e_ready = !m_busy;
            e_valid = m_busy && (cyc >= m_acc + m_lat - 1);
            e_rw    = m_busy && (m_fault == 2'b00) && m_store && (cyc == m_acc);
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("resp_valid", 32'(resp_valid), 32'(e_valid));
            chk("mem_rw", 32'(mem_rw), 32'(e_rw));
            chk("mem_func", 32'(mem_func), 32'(m_mfunc));
            chk("mem_addr", mem_addr, m_maddr);
            chk("mem_wdata", mem_wdata, m_mwdata);
            if (e_valid) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_fault", 32'(resp_fault), 32'(m_fault));
            end else if (m_zero) begin
                chk("reset_rdata", resp_rdata, 32'h0);
                chk("reset_fault", 32'(resp_fault), 32'h0);
            end
        end
        if (rst_n === 1'b0) begin
            m_live = 1; m_busy = 0; m_zero = 1;
            m_mfunc = '0; m_maddr = '0; m_mwdata = '0;
        end else if (m_live) begin
            if (e_rw) model_write(m_func, m_addr, m_wdata);
            if (e_valid && resp_ready === 1'b1) begin
                m_busy = 0;
            end else if (!m_busy && req_valid === 1'b1) begin
                m_busy  = 1;
                m_zero  = 0;
                m_acc   = cyc + 1;
                m_store = req_rw;
                m_func  = req_func;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                m_fault = model_fault(req_rw, req_func, req_addr);
                m_lat   = (m_fault != 2'b00) ? 1 : (req_rw ? 2 : 3);
                m_rdata = (m_fault == 2'b00 && !req_rw) ? model_read(req_func, req_addr) : 32'h0;
                if (m_fault == 2'b00) begin
                    m_mfunc = req_func; m_maddr = req_addr; m_mwdata = req_wdata;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_accept(output int acc);
        logic rdy;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic do_req(input logic rw, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic [1:0] ft, output int lat, output int rws);
        int acc, n0, r0;
        n0 = hs_q.size();
        r0 = rw_cnt;
        req_rw = rw; req_func = f; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        wait_accept(acc);
        req_valid = 1'b0;
        for (int k = 0; k < 20 && hs_q.size() == n0; k++) begin
            @(posedge clk); #1;
        end
        if (hs_q.size() == n0) begin
            chk("resp_timeout", 32'h0, 32'h1);
            rd = '0; ft = '0; lat = 0;
        end else begin
            rd  = hs_q[n0].rdata;
            ft  = hs_q[n0].fault;
            lat = hs_q[n0].cyc - acc + 1;
        end
        rws = rw_cnt - r0;
    endtask

    task automatic run(input string nm, input logic rw, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] erd, input logic [1:0] eft,
                       input int elat, input int erws);
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat, rws;
        do_req(rw, f, a, wd, rd, ft, lat, rws);
        chk({nm, "_rdata"}, rd, erd);
        chk({nm, "_fault"}, 32'(ft), 32'(eft));
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_memwr"}, 32'(rws), 32'(erws));
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'h1);
        chk({nm, "_resp_valid"}, 32'(resp_valid), 32'h0);
        chk({nm, "_resp_rdata"}, resp_rdata, 32'h0);
        chk({nm, "_resp_fault"}, 32'(resp_fault), 32'h0);
        chk({nm, "_mem_rw"}, 32'(mem_rw), 32'h0);
        chk({nm, "_mem_func"}, 32'(mem_func), 32'h0);
        chk({nm, "_mem_addr"}, mem_addr, 32'h0);
        chk({nm, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    logic [31:0] t6a [4] = '{32'h100, 32'h104, 32'h200, 32'h101};
    logic [2:0]  t6f [4] = '{3'b010, 3'b010, 3'b010, 3'b100};
    logic [31:0] t6e [4] = '{32'hDEAD80EF, 32'h00000055, 32'h0BADF00D, 32'h00000080};
    int          accs [4];

    initial begin
        int acc, acc2, n0;
        rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_func = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic store/load, sign/zero extension
        run("st_w_100",   1'b1, 3'b010, 32'h100,   32'hDEADBEEF, 32'h0,        2'b00, 2, 1);
        run("ld_w_100",   1'b0, 3'b010, 32'h100,   32'h0,        32'hDEADBEEF, 2'b00, 3, 0);
        run("st_b_101",   1'b1, 3'b000, 32'h101,   32'h80,       32'h0,        2'b00, 2, 1);
        run("ld_b_101",   1'b0, 3'b000, 32'h101,   32'h0,        32'hFFFFFF80, 2'b00, 3, 0);
        run("ld_bu_101",  1'b0, 3'b100, 32'h101,   32'h0,        32'h00000080, 2'b00, 3, 0);
        run("ld_h_102",   1'b0, 3'b001, 32'h102,   32'h0,        32'hFFFFDEAD, 2'b00, 3, 0);
        run("ld_w_100b",  1'b0, 3'b010, 32'h100,   32'h0,        32'hDEAD80EF, 2'b00, 3, 0);
        run("st_h_300",   1'b1, 3'b001, 32'h300,   32'h1234ABCD, 32'h0,        2'b00, 2, 1);
        run("ld_hu_300",  1'b0, 3'b101, 32'h300,   32'h0,        32'h0000ABCD, 2'b00, 3, 0);
        run("ld_h_300",   1'b0, 3'b001, 32'h300,   32'h0,        32'hFFFFABCD, 2'b00, 3, 0);
        // faults and priority
        run("ld_w_102",   1'b0, 3'b010, 32'h102,   32'h0,        32'h0,        2'b01, 1, 0);
        run("ld_h_103",   1'b0, 3'b001, 32'h103,   32'h0,        32'h0,        2'b01, 1, 0);
        run("st_h_301",   1'b1, 3'b001, 32'h301,   32'h5555,     32'h0,        2'b01, 1, 0);
        run("st_f101",    1'b1, 3'b101, 32'h100,   32'h0,        32'h0,        2'b11, 1, 0);
        run("st_f100",    1'b1, 3'b100, 32'h100,   32'h0,        32'h0,        2'b11, 1, 0);
        run("ld_f011",    1'b0, 3'b011, 32'h100,   32'h0,        32'h0,        2'b11, 1, 0);
        run("ld_f110",    1'b0, 3'b110, 32'h100,   32'h0,        32'h0,        2'b11, 1, 0);
        run("ld_w_10000", 1'b0, 3'b010, 32'h10000, 32'h0,        32'h0,        2'b10, 1, 0);
        run("ld_f011_oob",1'b0, 3'b011, 32'h10001, 32'h0,        32'h0,        2'b11, 1, 0);
        run("ld_w_10002", 1'b0, 3'b010, 32'h10002, 32'h0,        32'h0,        2'b01, 1, 0);
        run("st_w_10000", 1'b1, 3'b010, 32'h10000, 32'h11111111, 32'h0,        2'b10, 1, 0);
        run("ld_w_0",     1'b0, 3'b010, 32'h0,     32'h0,        32'h0,        2'b00, 3, 0);
        run("st_b_ffff",  1'b1, 3'b000, 32'hFFFF,  32'h7F,       32'h0,        2'b00, 2, 1);
        run("ld_bu_ffff", 1'b0, 3'b100, 32'hFFFF,  32'h0,        32'h0000007F, 2'b00, 3, 0);
        run("ld_b_10000", 1'b0, 3'b000, 32'h10000, 32'h0,        32'h0,        2'b10, 1, 0);
        run("ld_w_hi",    1'b0, 3'b010, 32'h80000000, 32'h0,     32'h0,        2'b10, 1, 0);

        // backpressure in RESP
        resp_ready = 1'b0;
        n0 = hs_q.size();
        req_rw = 1'b0; req_func = 3'b010; req_addr = 32'h100; req_wdata = '0; req_valid = 1'b1;
        wait_accept(acc);
        req_valid = 1'b0;
        for (int k = 0; k < 20 && resp_valid !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid_seen", 32'(resp_valid), 32'h1);
        req_rw = 1'b1; req_func = 3'b000; req_addr = 32'h104; req_wdata = 32'h55; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(resp_valid), 32'h1);
            chk("bp_hold_rdata", resp_rdata, 32'hDEAD80EF);
            chk("bp_hold_fault", 32'(resp_fault), 32'h0);
            chk("bp_hold_ready", 32'(req_ready), 32'h0);
        end
        chk("bp_no_handshake", 32'(hs_q.size()), 32'(n0));
        resp_ready = 1'b1;
        wait_accept(acc2);
        req_valid = 1'b0;
        chk("bp_handshake", 32'(hs_q.size()), 32'(n0 + 1));
        if (hs_q.size() > n0) chk("bp_accept_next", 32'(acc2), 32'(hs_q[n0].cyc + 2));
        for (int k = 0; k < 20 && hs_q.size() < n0 + 2; k++) begin
            @(posedge clk); #1;
        end
        chk("bp_store_resp", 32'(hs_q.size()), 32'(n0 + 2));
        run("ld_bu_104",  1'b0, 3'b100, 32'h104,   32'h0,        32'h00000055, 2'b00, 3, 0);

        // reset during store ISSUE
        run("st_w_200",   1'b1, 3'b010, 32'h200,   32'h0BADF00D, 32'h0,        2'b00, 2, 1);
        req_rw = 1'b1; req_func = 3'b010; req_addr = 32'h200; req_wdata = 32'h12345678; req_valid = 1'b1;
        wait_accept(acc);
        chk("rst_issue_rw", 32'(mem_rw), 32'h1);
        rst_n = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        chk_reset("midrst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", 32'(req_ready), 32'h1);
        run("ld_w_200",   1'b0, 3'b010, 32'h200,   32'h0,        32'h0BADF00D, 2'b00, 3, 0);

        // back-to-back loads, resp_ready held high
        n0 = hs_q.size();
        for (int i = 0; i < 4; i++) begin
            req_rw = 1'b0; req_func = t6f[i]; req_addr = t6a[i]; req_wdata = '0; req_valid = 1'b1;
            wait_accept(accs[i]);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 40 && hs_q.size() < n0 + 4; k++) begin
            @(posedge clk); #1;
        end
        chk("b2b_count", 32'(hs_q.size()), 32'(n0 + 4));
        if (hs_q.size() >= n0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("b2b_rdata", hs_q[n0 + i].rdata, t6e[i]);
                if (i > 0) begin
                    chk("b2b_accept_gap", 32'(accs[i] - accs[i-1]), 32'd4);
                    chk("b2b_resp_gap", 32'(hs_q[n0 + i].cyc - hs_q[n0 + i - 1].cyc), 32'd4);
                end
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
